// File: rtl/algo_4r4w1p_rdrsp_buf.sv
// Per-port read-response buffer: DEPTH-entry FIFO + issue credits, 1-cycle push-to-out latency (no bypass).
// Backpressure: out_rdy pops the head; a full FIFO drops unpopped pushes (sticky ovf). ALGO_RDRSP_ECCCNT_EN adds ECC counters.
module algo_4r4w1p_rdrsp_buf #(
  parameter int NUMRDPT = 4,
  parameter int WIDTH   = 64,
  parameter int BITPADR = 16,
  parameter int DEPTH   = 4,
  parameter int BITDPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUMRDPT-1:0]         read,
  input  logic [NUMRDPT-1:0]         rd_vld,
  input  logic [NUMRDPT*WIDTH-1:0]   rd_dout,
  input  logic [NUMRDPT-1:0]         rd_serr,
  input  logic [NUMRDPT-1:0]         rd_derr,
  input  logic [NUMRDPT*BITPADR-1:0] rd_padr,
  output logic [NUMRDPT-1:0]         rd_crd,
  output logic [NUMRDPT-1:0]         out_vld,
  input  logic [NUMRDPT-1:0]         out_rdy,
  output logic [NUMRDPT*WIDTH-1:0]   out_dout,
  output logic [NUMRDPT-1:0]         out_serr,
  output logic [NUMRDPT-1:0]         out_derr,
  output logic [NUMRDPT*BITPADR-1:0] out_padr,
  output logic [NUMRDPT-1:0]         ovf,
  output logic [NUMRDPT-1:0]         crd_err
`ifdef ALGO_RDRSP_ECCCNT_EN
  ,
  output logic [15:0]                serr_cnt,
  output logic [15:0]                derr_cnt
`endif
);

  localparam logic [BITDPTH:0] FULL = (BITDPTH+1)'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0]   dout;
    logic               serr;
    logic               derr;
    logic [BITPADR-1:0] padr;
  } ent_t;

  logic [NUMRDPT-1:0] push_v;

  for (genvar g = 0; g < NUMRDPT; g++) begin : g_port
    ent_t               mem_q [DEPTH];
    ent_t               wr_ent;
    ent_t               head;
    logic [BITDPTH:0]   cnt_q, cnt_d;
    logic [BITDPTH:0]   crd_q, crd_d;
    logic [BITDPTH-1:0] wptr_q, rptr_q;
    logic               ovf_q, cerr_q;
    logic               push, pop, ovf_set, cerr_set;

    assign wr_ent = '{dout: rd_dout[g*WIDTH +: WIDTH], serr: rd_serr[g],
                      derr: rd_derr[g], padr: rd_padr[g*BITPADR +: BITPADR]};

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
      pop     = (cnt_q != '0) && out_rdy[g];
      push    = rd_vld[g] && ((cnt_q != FULL) || pop);
      ovf_set = rd_vld[g] && (cnt_q == FULL) && !pop;
      cnt_d   = cnt_q;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end

    // Credit saturates at 0 and DEPTH; either clamp is flagged as a protocol error.
    always_comb begin
      crd_d    = crd_q;
      cerr_set = 1'b0;
      if (read[g] && !pop) begin
        if (crd_q == '0) cerr_set = 1'b1;
        else             crd_d    = crd_q - 1'b1;
      end else if (pop && !read[g]) begin
        if (crd_q == FULL) cerr_set = 1'b1;
        else               crd_d    = crd_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        cnt_q  <= '0;
        crd_q  <= FULL;
        wptr_q <= '0;
        rptr_q <= '0;
        ovf_q  <= 1'b0;
        cerr_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        crd_q  <= crd_d;
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop)  rptr_q <= rptr_q + 1'b1;
        ovf_q  <= ovf_q | ovf_set;
        cerr_q <= cerr_q | cerr_set;
      end
    end

    always_ff @(posedge clk) begin
      if (rst && push) mem_q[wptr_q] <= wr_ent;
    end

    assign head                             = mem_q[rptr_q];
    assign push_v[g]                        = push;
    assign out_vld[g]                       = (cnt_q != '0);
    assign rd_crd[g]                        = (crd_q != '0);
    assign out_dout[g*WIDTH +: WIDTH]       = head.dout;
    assign out_serr[g]                      = head.serr;
    assign out_derr[g]                      = head.derr;
    assign out_padr[g*BITPADR +: BITPADR]   = head.padr;
    assign ovf[g]                           = ovf_q;
    assign crd_err[g]                       = cerr_q;
  end

`ifdef ALGO_RDRSP_ECCCNT_EN
  logic [15:0] serr_cnt_q, serr_cnt_d;
  logic [15:0] derr_cnt_q, derr_cnt_d;
  logic [16:0] serr_sum, derr_sum;

  // One extra bit is enough headroom for NUMRDPT increments past 16'hFFFF.
  always_comb begin
    serr_sum = {1'b0, serr_cnt_q};
    derr_sum = {1'b0, derr_cnt_q};
    for (int i = 0; i < NUMRDPT; i++) begin
      serr_sum = serr_sum + 17'(push_v[i] & rd_serr[i]);
      derr_sum = derr_sum + 17'(push_v[i] & rd_derr[i]);
    end
    serr_cnt_d = serr_sum[16] ? 16'hFFFF : serr_sum[15:0];
    derr_cnt_d = derr_sum[16] ? 16'hFFFF : derr_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      serr_cnt_q <= '0;
      derr_cnt_q <= '0;
    end else begin
      serr_cnt_q <= serr_cnt_d;
      derr_cnt_q <= derr_cnt_d;
    end
  end

  assign serr_cnt = serr_cnt_q;
  assign derr_cnt = derr_cnt_q;
`endif

endmodule

// File: tb/tb_algo_4r4w1p_rdrsp_buf.sv
// Bench for algo_4r4w1p_rdrsp_buf: directed scenarios plus random traffic against a queue-based model.
module tb_algo_4r4w1p_rdrsp_buf;
  localparam int N = 4, W = 64, PA = 16, D = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    read, rd_vld, rd_serr, rd_derr, out_rdy;
  logic [N*W-1:0]  rd_dout;
  logic [N*PA-1:0] rd_padr;
  logic [N-1:0]    rd_crd, out_vld, out_serr, out_derr, ovf, crd_err;
  logic [N*W-1:0]  out_dout;
  logic [N*PA-1:0] out_padr;
`ifdef ALGO_RDRSP_ECCCNT_EN
  logic [15:0]     serr_cnt, derr_cnt;
`endif

  algo_4r4w1p_rdrsp_buf dut (
    .clk(clk), .rst(rst), .read(read), .rd_vld(rd_vld), .rd_dout(rd_dout),
    .rd_serr(rd_serr), .rd_derr(rd_derr), .rd_padr(rd_padr), .rd_crd(rd_crd),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_dout(out_dout), .out_serr(out_serr),
    .out_derr(out_derr), .out_padr(out_padr), .ovf(ovf), .crd_err(crd_err)
`ifdef ALGO_RDRSP_ECCCNT_EN
    , .serr_cnt(serr_cnt), .derr_cnt(derr_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  d;
    logic          s;
    logic          e;
    logic [PA-1:0] a;
  } ent_t;

  ent_t     mq[N][$];
  int       mcrd[N];
  logic [N-1:0] movf, mcerr;
  int       mserr, mderr;
  int       checks = 0, failures = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < N; p++) begin
      mq[p].delete();
      mcrd[p] = D;
    end
    movf = '0; mcerr = '0; mserr = 0; mderr = 0;
  endtask

  task automatic model_step();
    for (int p = 0; p < N; p++) begin
      int   sz = mq[p].size();
      bit   pop  = (sz > 0) && out_rdy[p];
      bit   push = rd_vld[p] && ((sz < D) || pop);
      int   nc;
      ent_t e;
      if (rd_vld[p] && sz == D && !pop) movf[p] = 1'b1;
      if (pop) void'(mq[p].pop_front());
      if (push) begin
        e.d = rd_dout[p*W +: W]; e.s = rd_serr[p]; e.e = rd_derr[p]; e.a = rd_padr[p*PA +: PA];
        mq[p].push_back(e);
        if (e.s) mserr = (mserr < 65535) ? mserr + 1 : 65535;
        if (e.e) mderr = (mderr < 65535) ? mderr + 1 : 65535;
      end
      nc = mcrd[p] - int'(read[p]) + int'(pop);
      if (nc < 0)      begin mcrd[p] = 0; mcerr[p] = 1'b1; end
      else if (nc > D) begin mcrd[p] = D; mcerr[p] = 1'b1; end
      else             mcrd[p] = nc;
    end
  endtask

  task automatic check_all();
    for (int p = 0; p < N; p++) begin
      check_val($sformatf("out_vld[%0d]", p), 64'(out_vld[p]), 64'(mq[p].size() > 0));
      if (mq[p].size() > 0) begin
        check_val($sformatf("out_dout[%0d]", p), out_dout[p*W +: W], mq[p][0].d);
        check_val($sformatf("out_serr[%0d]", p), 64'(out_serr[p]), 64'(mq[p][0].s));
        check_val($sformatf("out_derr[%0d]", p), 64'(out_derr[p]), 64'(mq[p][0].e));
        check_val($sformatf("out_padr[%0d]", p), 64'(out_padr[p*PA +: PA]), 64'(mq[p][0].a));
      end
      check_val($sformatf("rd_crd[%0d]", p), 64'(rd_crd[p]), 64'(mcrd[p] > 0));
      check_val($sformatf("ovf[%0d]", p), 64'(ovf[p]), 64'(movf[p]));
      check_val($sformatf("crd_err[%0d]", p), 64'(crd_err[p]), 64'(mcerr[p]));
    end
`ifdef ALGO_RDRSP_ECCCNT_EN
    check_val("serr_cnt", 64'(serr_cnt), 64'(mserr));
    check_val("derr_cnt", 64'(derr_cnt), 64'(mderr));
`endif
  endtask

  task automatic rand_data();
    for (int i = 0; i < N*W/32; i++) rd_dout[i*32 +: 32] = $urandom;
    rd_padr = {$urandom, $urandom};
  endtask

  // Called at a negedge: drive inputs, advance the model, sample at the next negedge.
  task automatic cycle(input logic [N-1:0] rd, input logic [N-1:0] vld, input logic [N-1:0] rdy,
                       input logic [N-1:0] se, input logic [N-1:0] de);
    read = rd; rd_vld = vld; out_rdy = rdy; rd_serr = se; rd_derr = de;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    read = 4'($urandom); rd_vld = 4'($urandom); out_rdy = 4'($urandom);
    rd_serr = 4'($urandom); rd_derr = 4'($urandom);
    rand_data();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    read = '0; rd_vld = '0; out_rdy = '0;
    check_all();
  endtask

  initial begin
    rst = 1'b0; read = '0; rd_vld = '0; out_rdy = '0; rd_serr = '0; rd_derr = '0;
    rd_dout = '0; rd_padr = '0;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset then idle
    do_reset();
    check_val("rst_rd_crd", 64'(rd_crd), 64'hF);
    check_val("rst_out_vld", 64'(out_vld), 64'h0);
    cycle('0, '0, '0, '0, '0);

    // Port 0 in-order delivery and credit return
    for (int k = 1; k <= 4; k++) begin
      rand_data();
      rd_dout[63:0] = 64'(17 * k);
      cycle(4'b0001, 4'b0001, '0, 4'($urandom), 4'($urandom));
    end
    check_val("p0_crd_empty", 64'(rd_crd[0]), 64'h0);
    for (int k = 1; k <= 4; k++) begin
      check_val("p0_order", out_dout[63:0], 64'(17 * k));
      cycle('0, '0, 4'b0001, '0, '0);
    end
    check_val("p0_crd_back", 64'(rd_crd[0]), 64'h1);

    // Port 1 overflow drop, then full push+pop accepted
    repeat (4) begin rand_data(); cycle('0, 4'b0010, '0, 4'($urandom), 4'($urandom)); end
    rd_dout[127:64] = 64'hAA;
    cycle('0, 4'b0010, '0, '0, '0);
    check_val("p1_ovf", 64'(ovf[1]), 64'h1);
    repeat (4) cycle('0, '0, 4'b0010, '0, '0);
    check_val("p1_drained", 64'(out_vld[1]), 64'h0);
    repeat (4) begin rand_data(); cycle('0, 4'b0010, '0, '0, '0); end
    rd_dout[127:64] = 64'hAA;
    cycle('0, 4'b0010, 4'b0010, '0, '0);
    repeat (3) cycle('0, '0, 4'b0010, '0, '0);
    check_val("p1_aa_last", out_dout[127:64], 64'hAA);

    // Port 2 credit underflow, then read+pop at credit 1
    repeat (4) cycle(4'b0100, '0, '0, '0, '0);
    check_val("p2_crd_zero", 64'(rd_crd[2]), 64'h0);
    cycle(4'b0100, '0, '0, '0, '0);
    check_val("p2_crd_err", 64'(crd_err[2]), 64'h1);
    repeat (2) begin rand_data(); cycle('0, 4'b0100, '0, '0, '0); end
    cycle('0, '0, 4'b0100, '0, '0);
    cycle(4'b0100, '0, 4'b0100, '0, '0);
    check_val("p2_crd_hold", 64'(rd_crd[2]), 64'h1);

    // Port 3 reset mid-traffic
    do_reset();
    repeat (3) begin rand_data(); cycle('0, 4'b1000, '0, 4'($urandom), 4'($urandom)); end
    do_reset();
    check_val("p3_rst_vld", 64'(out_vld[3]), 64'h0);
    check_val("p3_rst_crd", 64'(rd_crd[3]), 64'h1);

`ifdef ALGO_RDRSP_ECCCNT_EN
    do_reset();
    rand_data();
    cycle('0, 4'b1111, '0, 4'b1011, 4'b0100);
    check_val("ecc_serr3", 64'(serr_cnt), 64'd3);
    check_val("ecc_derr1", 64'(derr_cnt), 64'd1);
    repeat (16400) cycle('0, 4'b1111, 4'b1111, 4'b1111, 4'b1111);
    check_val("ecc_serr_sat", 64'(serr_cnt), 64'hFFFF);
    check_val("ecc_derr_sat", 64'(derr_cnt), 64'hFFFF);
`endif

    // Random traffic with occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rand_data();
      if ($urandom_range(0, 99) == 0) do_reset();
      else cycle(4'($urandom), 4'($urandom), 4'($urandom) & 4'($urandom),
                 4'($urandom), 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/algo_4r4w1p_rdrsp_buf.md
ALGO_4R4W1P_RDRSP_BUF -- requirements
Module: algo_4r4w1p_rdrsp_buf

Interface
REQ-001 Parameters (name, default, meaning): NUMRDPT, 4, read ports; WIDTH, 64, data bits per port; BITPADR, 16, physical-address bits per port; DEPTH, 4, FIFO entries per port (power of 2, ≥2); BITDPTH, 2, log2(DEPTH).
REQ-002 Ports (name direction width meaning): clk in 1 clock; rst in 1 synchronous active-low reset; read in NUMRDPT read issued to memory this cycle, per port; rd_vld in NUMRDPT memory read response valid; rd_dout in NUMRDPT*WIDTH response data; rd_serr in NUMRDPT single-bit error; rd_derr in NUMRDPT double-bit error; rd_padr in NUMRDPT*BITPADR response physical address.
REQ-003 Ports, continued: rd_crd out NUMRDPT port may issue a read (credit>0); out_vld out NUMRDPT buffered response available; out_rdy in NUMRDPT consumer accepts head; out_dout out NUMRDPT*WIDTH head data; out_serr out NUMRDPT; out_derr out NUMRDPT; out_padr out NUMRDPT*BITPADR; ovf out NUMRDPT sticky overflow; crd_err out NUMRDPT sticky credit underflow.
REQ-004 With ALGO_RDRSP_ECCCNT_EN: serr_cnt out 16 and derr_cnt out 16 also present.
REQ-005 Port i occupies bits [i*W +: W] of every packed bus; ports are fully independent.

Function
REQ-006 Per port: one DEPTH-entry FIFO storing {dout, serr, derr, padr}; count register BITDPTH+1 bits; credit register BITDPTH+1 bits.
REQ-007 Push when rd_vld[i]=1 and (count<DEPTH or pop same cycle); entry visible on out_* the next cycle (no bypass, latency 1).
REQ-008 Pop when out_vld[i]=1 and out_rdy[i]=1; out_vld[i]=1 iff count>0; out_* show the head entry combinationally from storage.
REQ-009 Full (count=DEPTH) with push and pop in same cycle: both occur, count stays DEPTH.
REQ-010 Full with push and no pop: data dropped, storage unchanged, ovf[i] set and held until reset.
REQ-011 Empty with out_rdy=1: no pop, count stays 0, pointers unchanged.
REQ-012 Read/write pointers BITDPTH bits, wrap from DEPTH-1 to 0.
REQ-013 Credit: read[i] decrements, pop increments; both same cycle leaves credit unchanged; rd_crd[i]=1 iff credit>0.
REQ-014 read[i]=1 with credit=0 and no pop: credit stays 0, crd_err[i] set and held until reset.
REQ-015 Credit never exceeds DEPTH; a pop at credit=DEPTH leaves it DEPTH and sets crd_err[i].
REQ-016 out_serr/out_derr pass stored flags unaltered; both may be 1.

Reset
REQ-017 When rst=0 at a clk edge: all counts=0, pointers=0, credits=DEPTH, ovf=0, crd_err=0, counters=0; FIFO storage not cleared.
REQ-018 Reset values of outputs: out_vld=0, rd_crd=all ones, ovf=0, crd_err=0, serr_cnt=derr_cnt=0; out_dout/out_padr undefined while out_vld=0.
REQ-019 Reset asserted mid-traffic discards all buffered entries; rd_vld, read and out_rdy during reset are ignored.

Configuration
REQ-020 Macro ALGO_RDRSP_ECCCNT_EN defined: serr_cnt/derr_cnt count pushed entries with serr/derr set, summed over all ports in one cycle (0..NUMRDPT added), saturating at 16'hFFFF.
REQ-021 Macro undefined: counter ports and logic absent; all other behaviour identical.

Verification
REQ-022 Reset then idle -> rd_crd=4'b1111, out_vld=0, credits=4 on all ports.
REQ-023 Port0: read 4 cycles, rd_vld with dout 0x11..0x44 -> rd_crd[0]=0 after 4th read; out_dout 0x11,0x22,0x33,0x44 in order under out_rdy=1; credit back to 4.
REQ-024 Port1 full (4 entries), rd_vld with dout 0xAA and out_rdy=0 -> ovf[1]=1, 0xAA never emitted; same with out_rdy=1 -> 0xAA accepted, count stays 4.
REQ-025 Port2 credit 0, read[2]=1 -> crd_err[2]=1, credit stays 0; read[2] and pop same cycle at credit 1 -> credit stays 1.
REQ-026 Macro defined: same cycle rd_vld=4'b1111 with rd_serr=4'b1011, rd_derr=4'b0100 -> serr_cnt=3, derr_cnt=1 next cycle; preset near 0xFFFF saturates.
REQ-027 rst=0 for one cycle with 3 entries buffered on port3 -> next cycle out_vld[3]=0, rd_crd[3]=1, credit=4.
